// File: rtl/bit_handshake_fifo.sv
// rtl/bit_handshake_fifo.sv - DEPTH-bit elastic buffer between four-phase req/ack bit ports.
// Optional BITFIFO_SYNC_EN adds two-flop synchronizers on req_in and ack_in.
module bit_handshake_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_in,
  input  logic              req_in,
  output logic              ack_out,
  output logic              data_out,
  output logic              req_out,
  input  logic              ack_in,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic req_s;
  logic ack_s;

`ifdef BITFIFO_SYNC_EN
  logic [1:0] req_sync;
  logic [1:0] ack_sync;

  always_ff @(posedge clk) begin
    if (!reset) begin
      req_sync <= '0;
      ack_sync <= '0;
    end else begin
      req_sync <= {req_sync[0], req_in};
      ack_sync <= {ack_sync[0], ack_in};
    end
  end

  assign req_s = req_sync[1];
  assign ack_s = ack_sync[1];
`else
  assign req_s = req_in;
  assign ack_s = ack_in;
`endif

  typedef enum logic {R_IDLE, R_ACK} r_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SETUP, T_REQ, T_RTZ} t_state_t;

  r_state_t          r_state;
  t_state_t          t_state;
  logic              mem [DEPTH];
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic              write_en;
  logic              pop_en;

  assign write_en = (r_state == R_IDLE) && req_s && (count != FULL_COUNT);
  assign pop_en   = (t_state == T_REQ) && ack_s;

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (reset && write_en) begin
      mem[wp] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= R_IDLE;
      ack_out <= 1'b0;
      wp      <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (write_en) begin
            wp      <= wp + 1'b1;
            ack_out <= 1'b1;
            r_state <= R_ACK;
          end
        end
        R_ACK: begin
          if (!req_s) begin
            ack_out <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // data_out is loaded one cycle ahead of req_out and held until the next T_IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      t_state  <= T_IDLE;
      req_out  <= 1'b0;
      data_out <= 1'b0;
      rp       <= '0;
    end else begin
      case (t_state)
        T_IDLE: begin
          if (count != '0) begin
            data_out <= mem[rp];
            t_state  <= T_SETUP;
          end
        end
        T_SETUP: begin
          req_out <= 1'b1;
          t_state <= T_REQ;
        end
        T_REQ: begin
          if (ack_s) begin
            req_out <= 1'b0;
            rp      <= rp + 1'b1;
            t_state <= T_RTZ;
          end
        end
        T_RTZ: begin
          if (!ack_s) begin
            t_state <= T_IDLE;
          end
        end
        default: t_state <= T_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else begin
      case ({write_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
